// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core definitions: load/store size codes and LSU state type
package riscv_pkg;

    // Load/store size codes as carried by the decoder's mem_size (funct3 encoding)
    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE        = 2'd0,
        LSU_WAIT_GNT    = 2'd1,
        LSU_WAIT_RVALID = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and sign/zero-extends a byte, halfword or word from a read word
//
// Ports:
//   offset_i  byte offset of the access within the word (address bits [1:0])
//   size_i    LDST_* size code
//   rdata_i   raw 32-bit word from data memory
//   data_o    extended load result
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [2:0]  size_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        // Halfwords are always 2-byte aligned, so only offset bit 1 matters
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
            LDST_BU: data_o = {24'd0, byte_sel};
            LDST_HU: data_o = {16'd0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_riscv.sv
// rtl/lsu_riscv.sv - load-store unit: fault check, lane alignment, req/gnt/rvalid handshake, core stall
//
// Ports:
//   clk_i, arstn_i                 clock, asynchronous active-low reset
//   lsu_req_i/we_i/size_i          memory instruction controls from the decoder
//   lsu_addr_i, lsu_data_i         ALU byte address, rs2 store data
//   lsu_data_o                     extended load result (completion cycle of a load)
//   lsu_stall_req_o, lsu_fault_o   core stall request, misaligned/illegal access
//   data_req_o .. data_wdata_o     data-memory request side
//   data_gnt_i, data_rvalid_i, data_rdata_i   data-memory response side
module lsu_riscv
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_fault_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_t  state;
    logic [31:0] reg_addr;
    logic [2:0]  reg_size;
    logic        reg_we;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;

    logic        fault;
    logic [3:0]  be_comb;
    logic [31:0] wdata_comb;
    logic        issue;
    logic        complete;
    logic        active;
    logic [31:0] load_data;

    always_comb begin
        fault      = 1'b0;
        be_comb    = 4'b0000;
        wdata_comb = lsu_data_i;
        case (lsu_size_i)
            LDST_B: begin
                be_comb    = 4'b0001 << lsu_addr_i[1:0];
                wdata_comb = {4{lsu_data_i[7:0]}};
            end
            LDST_H: begin
                fault      = lsu_addr_i[0];
                be_comb    = 4'b0011 << {lsu_addr_i[1], 1'b0};
                wdata_comb = {2{lsu_data_i[15:0]}};
            end
            LDST_W: begin
                fault      = (lsu_addr_i[1:0] != 2'b00);
                be_comb    = 4'b1111;
            end
            LDST_BU: begin
                fault      = lsu_we_i;
                be_comb    = 4'b0001 << lsu_addr_i[1:0];
            end
            LDST_HU: begin
                fault      = lsu_we_i | lsu_addr_i[0];
                be_comb    = 4'b0011 << {lsu_addr_i[1], 1'b0};
            end
            default: fault = 1'b1;
        endcase
    end

    assign issue = (state == LSU_IDLE) && lsu_req_i && !fault;

    always_comb begin
        case (state)
            LSU_IDLE:        complete = issue && data_gnt_i && lsu_we_i;
            LSU_WAIT_GNT:    complete = data_gnt_i && reg_we;
            LSU_WAIT_RVALID: complete = data_rvalid_i;
            default:         complete = 1'b0;
        endcase
    end

    lsu_load_align u_load_align (
        .offset_i (reg_addr[1:0]),
        .size_i   (reg_size),
        .rdata_i  (data_rdata_i),
        .data_o   (load_data)
    );

    // Outputs are gated by reset as well as lsu_req_i so that a reset in the
    // middle of an access drops the request without waiting for a clock edge.
    assign active = arstn_i && lsu_req_i;

    always_comb begin
        lsu_data_o      = 32'd0;
        lsu_stall_req_o = 1'b0;
        lsu_fault_o     = 1'b0;
        data_req_o      = 1'b0;
        data_we_o       = 1'b0;
        data_be_o       = 4'b0000;
        data_addr_o     = 32'd0;
        data_wdata_o    = 32'd0;
        if (active) begin
            case (state)
                LSU_IDLE: begin
                    lsu_fault_o = fault;
                    if (!fault) begin
                        data_req_o   = 1'b1;
                        data_we_o    = lsu_we_i;
                        data_be_o    = be_comb;
                        data_addr_o  = {lsu_addr_i[31:2], 2'b00};
                        data_wdata_o = wdata_comb;
                    end
                end
                LSU_WAIT_GNT: begin
                    data_req_o   = 1'b1;
                    data_we_o    = reg_we;
                    data_be_o    = reg_be;
                    data_addr_o  = {reg_addr[31:2], 2'b00};
                    data_wdata_o = reg_wdata;
                end
                LSU_WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        lsu_data_o = load_data;
                    end
                end
                default: ;
            endcase
            lsu_stall_req_o = !lsu_fault_o && !complete;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= LSU_IDLE;
            reg_addr  <= 32'd0;
            reg_size  <= 3'd0;
            reg_we    <= 1'b0;
            reg_be    <= 4'b0000;
            reg_wdata <= 32'd0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (issue) begin
                        reg_addr  <= lsu_addr_i;
                        reg_size  <= lsu_size_i;
                        reg_we    <= lsu_we_i;
                        reg_be    <= be_comb;
                        reg_wdata <= wdata_comb;
                        if (data_gnt_i) begin
                            state <= lsu_we_i ? LSU_IDLE : LSU_WAIT_RVALID;
                        end else begin
                            state <= LSU_WAIT_GNT;
                        end
                    end
                end
                LSU_WAIT_GNT: begin
                    if (data_gnt_i) begin
                        state <= reg_we ? LSU_IDLE : LSU_WAIT_RVALID;
                    end
                end
                LSU_WAIT_RVALID: begin
                    if (data_rvalid_i) begin
                        state <= LSU_IDLE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: doc/lsu_riscv.md
# lsu_riscv

Load-store unit sitting directly downstream of the instruction decoder in the RISC-V core. It consumes the decoder's memory controls (`mem_req`, `mem_we`, `mem_size`) together with the ALU-computed address and the rs2 store data. It drives a request/grant/rvalid data-memory port and stalls the core until each access completes. It also performs byte-lane alignment, byte-enable generation and load sign/zero extension.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports (clock and reset first):
- `clk_i`  in  1  core clock
- `arstn_i`  in  1  asynchronous, active-low reset
- `lsu_req_i`  in  1  memory instruction present (decoder `mem_req_o`); held stable by the core while `lsu_stall_req_o`=1
- `lsu_we_i`  in  1  1 = store, 0 = load (decoder `mem_we_o`)
- `lsu_size_i`  in  3  `LDST_B/H/W/BU/HU` encoding (decoder `mem_size_o`)
- `lsu_addr_i`  in  32  byte address from the ALU
- `lsu_data_i`  in  32  store data (rs2)
- `lsu_data_o`  out  32  extended load result; valid in the completion cycle of a load
- `lsu_stall_req_o`  out  1  core must hold PC/pipeline this cycle
- `lsu_fault_o`  out  1  misaligned address or illegal size; the access is not issued
- `data_req_o`  out  1  memory request
- `data_we_o`  out  1  memory write enable
- `data_be_o`  out  4  byte enables
- `data_addr_o`  out  32  word address, bits[1:0]=0
- `data_wdata_o`  out  32  lane-replicated store data
- `data_gnt_i`  in  1  request accepted this cycle
- `data_rvalid_i`  in  1  read data valid; at least 1 cycle after the grant
- `data_rdata_i`  in  32  read word

## Operation
- **Fault check** (combinational on inputs):
  - H/HU with `addr[0]`=1 is a fault.
  - W with `addr[1:0]`≠0 is a fault.
  - Size 3'b011, 3'b110 or 3'b111 is a fault.
  - A store with size BU/HU is a fault.
  - On a fault while in IDLE with `lsu_req_i`=1: `lsu_fault_o`=1, no memory request, stall=0.
- **Byte enables:**
  - B: `4'b0001<<addr[1:0]`
  - H: `4'b0011<<{addr[1],1'b0}`
  - W: `4'b1111`
- **Store data:**
  - B: `{4{d[7:0]}}`
  - H: `{2{d[15:0]}}`
  - W: `d`
- **Load extract:** select the byte or halfword at the captured offset. B/H sign-extend; BU/HU zero-extend; W passes through.
- **FSM states:** IDLE, WAIT_GNT, WAIT_RVALID.
  - **IDLE:**
    - `data_req_o` = `lsu_req_i` & ~fault; memory outputs driven from the inputs.
    - On issue, register addr, size, we, be and wdata.
    - If the grant arrives the same cycle: a store completes (stall=0, stay IDLE); a load goes to WAIT_RVALID.
    - If there is no grant, go to WAIT_GNT.
  - **WAIT_GNT:**
    - `data_req_o`=1, all memory outputs from the registered copies.
    - On grant: a store completes and returns to IDLE; a load goes to WAIT_RVALID.
  - **WAIT_RVALID:**
    - `data_req_o`=0.
    - On `data_rvalid_i`: `lsu_data_o` = extract(`data_rdata_i`), stall=0, go to IDLE.
- **Stall:** `lsu_stall_req_o` = `lsu_req_i` & ~fault & ~complete_this_cycle.
- **Ignored inputs:** `data_rvalid_i` in IDLE/WAIT_GNT and `data_gnt_i` outside a request are ignored.

## Timing
- **Reset:** state=IDLE and all registers 0. While reset is asserted or `lsu_req_i`=0: all outputs are 0.
- **Reset mid-access:** `data_req_o` drops immediately (asynchronously). A later stray `rvalid` is ignored.
- **Latency:**
  - Store with grant in the issue cycle: 0 stall cycles.
  - Load: ≥1 stall cycle; completes in the rvalid cycle.
  - Each cycle of grant or rvalid delay adds one stall cycle.
- **Back-to-back:** after completion, the FSM is IDLE in the next cycle and may issue the next instruction's access in that same cycle.
- **Output stability:** `data_addr_o`, `data_be_o`, `data_we_o` and `data_wdata_o` are stable from request until grant.

## Structure
- Add an `lsu_state_t` enum (IDLE/WAIT_GNT/WAIT_RVALID) to the shared `riscv_pkg`.
- `LDST_*` size codes stay in the shared defines; no local redefinition.
- One combinational sub-module is natural: `lsu_load_align` (offset + size + rdata → extended result).

## Test plan
- LB at 0x1003, rdata 0x80AA_BBCC, gnt in the issue cycle, rvalid next cycle:
  - `data_addr_o`=0x1000, be=4'b1000
  - `lsu_data_o`=0xFFFF_FF80; stall for exactly 1 cycle
- SH at 0x2002, data 0x1234_ABCD, gnt delayed 2 cycles:
  - be=4'b1100, wdata=0xABCD_ABCD
  - outputs stable for 3 cycles; 2 stall cycles
- LHU at 0x3002, rdata 0x8001_0000:
  - result 0x0000_8001
- LW at 0x4001:
  - `lsu_fault_o`=1, `data_req_o`=0, stall=0
  - same for SW at 0x4002 and size 3'b011
- Back-to-back LW/SW, with the grant withheld on the second access:
  - second `data_req_o` rises in the first cycle after the load completes
- Assert `arstn_i` while in WAIT_RVALID, then pulse rvalid:
  - `data_req_o`=0, stall=0
  - the stray rvalid is ignored; the FSM stays IDLE
